// File: rtl/arith_seq_divider_pkg.sv
// Shared ALU definitions for the sequential divider: the status word layout
// used across the ALU status path and the divider state encoding.
package arith_seq_divider_pkg;

  // Status word width and bit positions (carry, over, zero, sign)
  localparam int STATUS_W = 4;
  localparam int ST_CARRY = 3;
  localparam int ST_OVER  = 2;
  localparam int ST_ZERO  = 1;
  localparam int ST_SIGN  = 0;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } divState_t;

endpackage

// File: rtl/arith_seq_divider_if.sv
// Request/result bundle between the execute stage and the sequential divider.
interface arith_seq_divider_if
  import arith_seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic                start;
  logic                signed_op;
  logic [WIDTH-1:0]    dividend;
  logic [WIDTH-1:0]    divisor;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    quotient;
  logic [WIDTH-1:0]    remainder;
  logic [STATUS_W-1:0] status;

  // The requester drives the operands and watches the results
  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, status
  );

  // The divider consumes the operands and produces the results
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, status
  );

endinterface

// File: rtl/arith_seq_divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and restore on borrow.
module arith_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisorExt;

  // The shifted remainder needs WIDTH+1 bits; the compare is the borrow test
  // and, when it succeeds, the true difference always fits back in WIDTH bits
  always_comb begin
    shifted    = {rem_i, bit_i};
    divisorExt = {1'b0, divisor_i};
    qbit_o     = (shifted >= divisorExt);
    rem_o      = qbit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/arith_seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU) with start/done handshake and the
// shared four-bit ALU status word. Latency is WIDTH+1 cycles from acceptance.
module arith_seq_divider
  import arith_seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clock,
  input logic               reset_n,
  arith_seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  divState_t           state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WIDTH-1:0]    dvd_q, dvd_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    dvsMag_q, dvsMag_d;
  logic [WIDTH-1:0]    origDvd_q, origDvd_d;
  logic                signedOp_q, signedOp_d;
  logic                dvdNeg_q, dvdNeg_d;
  logic                dvsNeg_q, dvsNeg_d;
  logic [WIDTH-1:0]    quotient_q, quotient_d;
  logic [WIDTH-1:0]    remainder_q, remainder_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic                done_q, done_d;

  logic [WIDTH-1:0]    stepRem;
  logic                stepBit;
  logic [WIDTH-1:0]    fixQuot;
  logic [WIDTH-1:0]    fixRem;
  logic [STATUS_W-1:0] fixStatus;

  // dvd_q shifts out dividend bits at the top and takes quotient bits in at the bottom
  arith_div_step #(.WIDTH(WIDTH)) uStep (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvsMag_q),
    .rem_o     (stepRem),
    .qbit_o    (stepBit)
  );

  // Sign fixup and special-case overrides applied to the finished magnitudes
  always_comb begin
    fixQuot   = (signedOp_q && (dvdNeg_q ^ dvsNeg_q)) ? -dvd_q : dvd_q;
    fixRem    = (signedOp_q && dvdNeg_q) ? -rem_q : rem_q;
    fixStatus = '0;
    if (dvsMag_q == '0) begin
      fixQuot             = '1;
      fixRem              = origDvd_q;
      fixStatus[ST_CARRY] = 1'b1;
      fixStatus[ST_OVER]  = 1'b1;
    end else if (signedOp_q && (origDvd_q == MOST_NEG) && dvsNeg_q &&
                 (dvsMag_q == WIDTH'(1))) begin
      fixQuot            = MOST_NEG;
      fixRem             = '0;
      fixStatus[ST_OVER] = 1'b1;
    end
    fixStatus[ST_ZERO] = (fixQuot == '0);
    fixStatus[ST_SIGN] = signedOp_q & fixQuot[WIDTH-1];
  end

  // Next-state logic: accept in IDLE, iterate WIDTH times in CALC, publish in FIX
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dvsMag_d    = dvsMag_q;
    origDvd_d   = origDvd_q;
    signedOp_d  = signedOp_q;
    dvdNeg_d    = dvdNeg_q;
    dvsNeg_d    = dvsNeg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    status_d    = status_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          signedOp_d = bus.signed_op;
          dvdNeg_d   = bus.signed_op & bus.dividend[WIDTH-1];
          dvsNeg_d   = bus.signed_op & bus.divisor[WIDTH-1];
          origDvd_d  = bus.dividend;
          dvd_d      = (bus.signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
          dvsMag_d   = (bus.signed_op && bus.divisor[WIDTH-1]) ? -bus.divisor : bus.divisor;
          rem_d      = '0;
          count_d    = CW'(WIDTH - 1);
          state_d    = CALC;
        end
      end
      CALC: begin
        rem_d = stepRem;
        dvd_d = {dvd_q[WIDTH-2:0], stepBit};
        if (count_q == '0) begin
          state_d = FIX;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      FIX: begin
        quotient_d  = fixQuot;
        remainder_d = fixRem;
        status_d    = fixStatus;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous abort to the reset values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dvsMag_q    <= '0;
      origDvd_q   <= '0;
      signedOp_q  <= 1'b0;
      dvdNeg_q    <= 1'b0;
      dvsNeg_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      status_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dvsMag_q    <= dvsMag_d;
      origDvd_q   <= origDvd_d;
      signedOp_q  <= signedOp_d;
      dvdNeg_q    <= dvdNeg_d;
      dvsNeg_q    <= dvsNeg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      status_q    <= status_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_arith_seq_divider.sv
// Randomised and directed checks of arith_seq_divider against a plain
// arithmetic reference model.
module tb_arith_seq_divider;
  import arith_seq_divider_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clock;
  logic reset_n;
  int   assertCount;
  int   failCount;

  arith_seq_divider_if #(.WIDTH(W)) bus ();

  arith_seq_divider #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, period 10
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference results straight from the arithmetic definition of DIV/DIVU
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic [STATUS_W-1:0] st);
    st = '0;
    if (b == '0) begin
      q = '1;
      r = a;
      st[ST_CARRY] = 1'b1;
      st[ST_OVER]  = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
      st[ST_OVER] = 1'b1;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    st[ST_ZERO] = (q == '0);
    st[ST_SIGN] = s & q[W-1];
  endfunction

  // Issues one request from the current (off-edge) time and waits for done
  task automatic doDivide(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic [STATUS_W-1:0] st, output bit hsOk, output bit holdOk);
    logic [W-1:0] prevQ;
    prevQ         = bus.quotient;
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.signed_op = s;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    hsOk   = (bus.busy === 1'b1) && (bus.done === 1'b0);
    holdOk = 1'b1;
    lat    = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (bus.done === 1'b1) begin
        lat = n;
        if (bus.busy !== 1'b0) hsOk = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) hsOk = 1'b0;
      if (bus.quotient !== prevQ) holdOk = 1'b0;
    end
    q  = bus.quotient;
    r  = bus.remainder;
    st = bus.status;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    assertCount++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.status} !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_values: got busy=%b done=%b q=%h r=%h st=%b, expected all zero",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.status);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Runs one directed case and checks result, latency and handshake
  task automatic test_case(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    int lat; bit hsOk, holdOk;
    logic [W-1:0] q, r, eq, er;
    logic [STATUS_W-1:0] st, est;
    model(a, b, s, eq, er, est);
    @(negedge clock);
    doDivide(a, b, s, lat, q, r, st, hsOk, holdOk);
    assertCount++;
    if ({q, r, st} !== {eq, er, est}) begin
      failCount++;
      $display("[TB] FAIL %s_result: got q=%h r=%h st=%b, expected q=%h r=%h st=%b", name, q, r, st, eq, er, est);
    end
    assertCount++;
    if (lat !== LAT) begin
      failCount++;
      $display("[TB] FAIL %s_latency: got %0d, expected %0d", name, lat, LAT);
    end
    assertCount++;
    if (!hsOk || !holdOk) begin
      failCount++;
      $display("[TB] FAIL %s_handshake: got busyDoneOk=%b holdOk=%b, expected 1 1", name, hsOk, holdOk);
    end
  endtask

  task automatic test_directed();
    test_case("udiv_100_7", 32'd100, 32'd7, 1'b0);
    test_case("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    test_case("sdiv_by_zero", 32'd5, 32'd0, 1'b1);
    test_case("udiv_by_zero", 32'd5, 32'd0, 1'b0);
    test_case("sdiv_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    test_case("udiv_3_10", 32'd3, 32'd10, 1'b0);
    test_case("udiv_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
  endtask

  task automatic test_start_ignored();
    int lat;
    lat = -1;
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.signed_op = 1'b0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (n == 5) begin
        bus.start = 1'b1; bus.dividend = 32'd1; bus.divisor = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    assertCount++;
    if (lat !== LAT || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
      failCount++;
      $display("[TB] FAIL start_ignored: got lat=%0d q=%h r=%h, expected lat=%0d q=%h r=%h",
               lat, bus.quotient, bus.remainder, LAT, 32'd14, 32'd2);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit sawDone;
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.signed_op = 1'b0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    assertCount++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.status} !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_abort_values: got busy=%b done=%b q=%h r=%h st=%b, expected all zero",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.status);
    end
    @(negedge clock);
    reset_n = 1'b1;
    sawDone = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) sawDone = 1'b1;
    end
    assertCount++;
    if (sawDone) begin
      failCount++;
      $display("[TB] FAIL reset_abort_quiet: got activity after abort=1, expected 0");
    end
    test_case("after_reset", 32'd1000, 32'd33, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat; bit hsOk, holdOk;
    logic [W-1:0] q, r, eq, er;
    logic [STATUS_W-1:0] st, est;
    @(negedge clock);
    doDivide(32'd1000, 32'd10, 1'b0, lat, q, r, st, hsOk, holdOk);
    // done is high right now, so this request lands on the very next edge
    model(32'hFFFF_FF9C, 32'd7, 1'b1, eq, er, est);
    doDivide(32'hFFFF_FF9C, 32'd7, 1'b1, lat, q, r, st, hsOk, holdOk);
    assertCount++;
    if ({q, r, st} !== {eq, er, est} || lat !== LAT || !hsOk) begin
      failCount++;
      $display("[TB] FAIL back_to_back: got q=%h r=%h st=%b lat=%0d hs=%b, expected q=%h r=%h st=%b lat=%0d hs=1",
               q, r, st, lat, hsOk, eq, er, est, LAT);
    end
  endtask

  task automatic test_random();
    int lat; bit hsOk, holdOk;
    logic [W-1:0] a, b, q, r, eq, er;
    logic [STATUS_W-1:0] st, est;
    bit s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 4 == 1) b = $urandom_range(1, 255);
      if (i % 4 == 2) b = -$urandom_range(1, 255);
      if (i == 7) b = '0;
      if (i == 11) begin a = 32'h8000_0000; b = '1; s = 1'b1; end
      model(a, b, s, eq, er, est);
      @(negedge clock);
      doDivide(a, b, s, lat, q, r, st, hsOk, holdOk);
      assertCount++;
      if ({q, r, st} !== {eq, er, est} || lat !== LAT || !hsOk || !holdOk) begin
        failCount++;
        $display("[TB] FAIL random_%0d: a=%h b=%h s=%b got q=%h r=%h st=%b lat=%0d hs=%b hold=%b, expected q=%h r=%h st=%b lat=%0d",
                 i, a, b, s, q, r, st, lat, hsOk, holdOk, eq, er, est, LAT);
      end
    end
  endtask

  // Sequence of scenarios followed by the summary line
  initial begin
    assertCount = 0;
    failCount   = 0;
    reset_n     = 1'b0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/arith_seq_divider.md
# arith_seq_divider

Multi-cycle restoring integer divider producing quotient, remainder and the standard four-bit ALU status word (carry, over, zero, sign) for the ALU status path. It performs the inverse of the ripple-carry add path: one trial subtraction per cycle, with start/done handshaking, so the execute stage can stall on `busy` for DIV/DIVU without a combinational divider on the critical path.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width; must be ≥ 2.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while idle.
- `signed_op`  in  1  1 = two's-complement (DIV), 0 = unsigned (DIVU); sampled with `start`.
- `dividend`  in  WIDTH  numerator; sampled with `start`.
- `divisor`  in  WIDTH  denominator; sampled with `start`.
- `busy`  out  1  high while a division is in flight.
- `done`  out  1  one-cycle pulse when results become valid.
- `quotient`  out  WIDTH  result; held until the next accepted `start`.
- `remainder`  out  WIDTH  result; held until the next accepted `start`.
- `status`  out  4  ALU status word in the shared field layout (carry/over/zero/sign).

## Operation
- States: IDLE → CALC → FIX → IDLE.
- IDLE: `start`=1 latches the operands and `signed_op`. It latches |dividend| and |divisor| when signed, clears the partial remainder and sets the counter to WIDTH-1. The state then goes to CALC.
- CALC, once per cycle:
  - Shift the next dividend MSB into the partial remainder.
  - Trial-subtract the divisor using WIDTH+1-bit arithmetic.
  - No borrow: keep the difference and set quotient bit = 1. Borrow: restore and set quotient bit = 0.
  - Leave CALC after the counter reaches 0, which is exactly WIDTH iterations.
- FIX: apply the signs. The quotient is negated if the operand signs differ. The remainder takes the sign of the dividend. Then register the outputs and `status`, pulse `done`, and return to IDLE.
- Divide by zero (divisor = 0): quotient = all ones, remainder = the original dividend, carry=1, over=1.
- Signed overflow (signed, dividend = 1 followed by WIDTH-1 zeros (most-negative value), divisor = all ones (-1)): quotient = the most-negative value, remainder = 0, over=1, carry=0.
- Both special cases keep the normal latency. The datapath runs anyway and FIX overrides the result.
- Status, normal case:
  - carry=0, over=0.
  - zero = (quotient == 0).
  - sign = quotient[WIDTH-1] when signed, 0 when unsigned.
- `start` while `busy` is ignored, with no queueing. `start` in the same cycle `done` is high is accepted, because the state is IDLE on that edge only if FIX has completed. Here FIX→IDLE and acceptance happen in back-to-back cycles.

## Timing
- Reset, asynchronous: state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `status`=0.
- `start` accepted at edge T0.
- `busy` is high from after T0 through the edge of T0+WIDTH+1.
- `done`, `quotient`, `remainder` and `status` are valid after edge T0+WIDTH+1. Latency is WIDTH+1 cycles (33 at the default width).
- `done` is high for exactly one cycle. `busy` and `done` are never high together.
- Results are stable from `done` until the edge after the next accepted `start`. During a computation they hold the previous values.
- `reset_n` low mid-operation aborts immediately to the reset values. No `done` is produced for the aborted operation.

## Structure
- Shared ALU package: status field indices and width (carry, over, zero, sign), plus the state encoding constants IDLE/CALC/FIX.
- One sub-module, `arith_div_step`: a combinational WIDTH+1-bit shift/trial-subtract/restore step. It outputs the next partial remainder and the quotient bit. The FSM, counter and sign fixup stay in the top level.

## Test plan
- Unsigned 100 / 7 -> quotient=14, remainder=2, status=0, `done` exactly 33 cycles after `start`.
- Signed -7 / 2 (0xFFFFFFF9 / 2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, sign=1, zero=0.
- Divide by zero 5 / 0 (signed and unsigned) -> quotient=0xFFFFFFFF, remainder=5, carry=1, over=1, same latency.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, over=1, sign=1.
- Unsigned 3 / 10 -> quotient=0, remainder=3, zero=1.
- Handshake and reset:
  - Second `start` with 1/1 pulsed at cycle 5 of 100/7 -> ignored; the 100/7 result is unchanged.
  - `reset_n` low at cycle 10 -> all outputs 0 and no `done`.
  - A new `start` after reset -> normal 33-cycle result.
